hdmi_period_sequencer: RTL and testbench
========================================

# hdmi_period_sequencer

Sequences the HDMI period structure (control, video preamble, video guard band, active video) ahead of the three TMDS encoders. It sits between the VGA timing generator/image generator and the TMDS encoders. It delays pixel data and sync by a fixed latency so that the 8-cycle preamble and 2-cycle leading guard band can be inserted before every active-video run. Per-channel control bits and a guard flag are driven so the encoder wrapper selects the TMDS code for each period.

## Interface
- PREAMBLE_LEN, 8, preamble length in cycles; legal 1..16
- GUARD_LEN, 2, leading guard-band length in cycles; legal 1..4
- LAT (derived, not overridable), PREAMBLE_LEN+GUARD_LEN+1, input-to-output latency in cycles
- Single clock `pixclk`; reset `rst` is asynchronous and active-high.
- pixclk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous active-high reset
- de_in  in  1  draw-area flag from timing generator
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- rgb_in  in  24  {red, green, blue} pixel
- err_clr  in  1  clears err_short_blank
- rgb_out  out  24  rgb_in delayed by LAT
- hsync_out  out  1  hsync_in delayed by LAT
- vsync_out  out  1  vsync_in delayed by LAT
- vde_out  out  1  1 when state is VIDEO; drives encoder VDE
- ctl_out  out  4  {CTL3,CTL2,CTL1,CTL0}; ch1 CD={CTL1,CTL0}, ch2 CD={CTL3,CTL2}
- guard_out  out  1  1 during guard band
- period_out  out  2  00 CTRL, 01 PRE, 10 GUARD, 11 VIDEO
- err_short_blank  out  1  sticky: rising de_in rejected

## Operation
- Delay line: de, hsync, vsync and rgb each pass through LAT register stages. The tap feeding the output stage is de_nxt (the de value that appears at the output on the next cycle).
- Rising-edge detect: rise = de_in & ~de_prev. de_prev resets to 1, so a line already active when reset is released is never sequenced.
- FSM, registered, state = period_out:
  - CTRL: on rise → PRE, phase counter cleared.
  - PRE: lasts exactly PREAMBLE_LEN cycles → GUARD.
  - GUARD: lasts exactly GUARD_LEN cycles → VIDEO.
  - VIDEO: stays while de_nxt=1; → CTRL on the cycle de_nxt=0.
- Rise while state≠CTRL (blanking shorter than LAT):
  - The rise is ignored and err_short_blank is set.
  - That line's data still flows through the delay line with vde_out=0, so the encoders send control codes instead.
- Outputs per state:
  - CTRL: ctl_out=0000, guard_out=0, vde_out=0.
  - PRE: ctl_out=0001, guard_out=0, vde_out=0.
  - GUARD: ctl_out=0000, guard_out=1, vde_out=0. Downstream codes: ch0/ch2 10'b1011001100, ch1 10'b0100110011.
  - VIDEO: ctl_out=0000, guard_out=0, vde_out=1.
- Channel 0 control data is always {vsync_out,hsync_out}, independent of this block's state.
- err_short_blank: set by a rejected rise. err_clr clears it. If both occur in the same cycle, set wins.
- The phase counter is 5 bits. It is compared with PREAMBLE_LEN-1 and GUARD_LEN-1 and never wraps within a state.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - State CTRL; all delay-line stages 0; de_prev=1.
  - All outputs 0, including err_short_blank.
- Rise sampled at edge t:
  - period_out=PRE on cycles t+1..t+PREAMBLE_LEN.
  - GUARD on the next GUARD_LEN cycles.
  - VIDEO from t+LAT, the same cycle the first delayed pixel appears on rgb_out.
- de_in falling at edge f: VIDEO ends and CTRL starts at f+LAT.
- Active run length N≥1: vde_out is high for exactly N cycles, aligned with the delayed pixels.
- Minimum accepted blanking: the rise must arrive at or after the cycle period_out returns to CTRL, i.e. blanking ≥ LAT cycles (11 with defaults). 10 cycles of blanking → rejected.
- Sync outputs are aligned with rgb_out in every state.
- Reset mid-line: the line is dropped and outputs are 0 immediately. The next rise after release starts a normal sequence.

## Test plan
- Reset with de_in=1, release, hold 640 active cycles → period_out stays 00, vde_out=0 until the next rise.
- Standard 800x525 timing, 640 active → per line: 8 PRE cycles (ctl_out=0001), 2 GUARD, 640 VIDEO; rgb_out[k] equals rgb_in from 11 cycles earlier.
- Single-cycle active pulse → PRE 8, GUARD 2, VIDEO 1, CTRL; err_short_blank=0.
- Two active runs separated by 11 blank cycles → both sequenced. Repeat with 10 blank cycles → second rejected: err_short_blank=1, vde_out=0 for its 5 data cycles.
- err_clr asserted in the same cycle as a rejected rise → err_short_blank=1; err_clr alone on a later cycle → 0.
- Assert rst during VIDEO → all outputs 0 asynchronously; after release the next line shows the exact 8/2 sequence.

Source files
------------

// File: rtl/hdmi_period_sequencer_if.sv
// Signal bundle between the timing/image source and the HDMI period sequencer.
// The master drives pixel, sync and error-clear inputs; the slave returns period controls.
interface hdmi_period_sequencer_if;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [23:0] rgb_in;
  logic        err_clr;
  logic [23:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        vde_out;
  logic [3:0]  ctl_out;
  logic        guard_out;
  logic [1:0]  period_out;
  logic        err_short_blank;

  modport master (
    output de_in, hsync_in, vsync_in, rgb_in, err_clr,
    input  rgb_out, hsync_out, vsync_out, vde_out, ctl_out, guard_out,
           period_out, err_short_blank
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, rgb_in, err_clr,
    output rgb_out, hsync_out, vsync_out, vde_out, ctl_out, guard_out,
           period_out, err_short_blank
  );
endinterface

// File: rtl/hdmi_period_sequencer.sv
// Delays pixel/sync by LAT cycles and inserts preamble + leading guard band
// ahead of each active-video run, driving the TMDS encoder period controls.
module hdmi_period_sequencer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input logic                    pixclk,
  input logic                    rst,
  hdmi_period_sequencer_if.slave bus
);

  localparam int LAT = PREAMBLE_LEN + GUARD_LEN + 1;
  localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] GUARD_LAST = 5'(GUARD_LEN - 1);

  typedef enum logic [1:0] {
    CTRL  = 2'b00,
    PRE   = 2'b01,
    GUARD = 2'b10,
    VIDEO = 2'b11
  } period_t;

  logic        de_dly  [LAT];
  logic        hs_dly  [LAT];
  logic        vs_dly  [LAT];
  logic [23:0] rgb_dly [LAT];

  logic        de_prev;
  logic        de_nxt;
  logic        rise;
  logic        reject;
  period_t     state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        err, err_nxt;

  // Delay line: stage 0 captures the inputs, stage LAT-1 feeds the outputs
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        de_dly[i]  <= 1'b0;
        hs_dly[i]  <= 1'b0;
        vs_dly[i]  <= 1'b0;
        rgb_dly[i] <= 24'd0;
      end
    end else begin
      de_dly[0]  <= bus.de_in;
      hs_dly[0]  <= bus.hsync_in;
      vs_dly[0]  <= bus.vsync_in;
      rgb_dly[0] <= bus.rgb_in;
      for (int i = 1; i < LAT; i++) begin
        de_dly[i]  <= de_dly[i-1];
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
        rgb_dly[i] <= rgb_dly[i-1];
      end
    end
  end

  // de_prev resets high so a line already active at reset release is skipped
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      de_prev <= 1'b1;
      state   <= CTRL;
      cnt     <= 5'd0;
      err     <= 1'b0;
    end else begin
      de_prev <= bus.de_in;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
    end
  end

  assign de_nxt = de_dly[LAT-2];
  assign rise   = bus.de_in & ~de_prev;
  assign reject = rise & (state != CTRL);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      CTRL: begin
        if (rise) begin
          state_nxt = PRE;
          cnt_nxt   = 5'd0;
        end
      end
      PRE: begin
        if (cnt == PRE_LAST) begin
          state_nxt = GUARD;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = VIDEO;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      VIDEO: begin
        if (!de_nxt) state_nxt = CTRL;
      end
      default: state_nxt = CTRL;
    endcase
    // A rejected rise outranks a simultaneous clear
    if (reject) err_nxt = 1'b1;
    else if (bus.err_clr) err_nxt = 1'b0;
  end

  assign bus.rgb_out         = rgb_dly[LAT-1];
  assign bus.hsync_out       = hs_dly[LAT-1];
  assign bus.vsync_out       = vs_dly[LAT-1];
  assign bus.period_out      = state;
  assign bus.vde_out         = (state == VIDEO);
  assign bus.guard_out       = (state == GUARD);
  assign bus.ctl_out         = {3'b000, (state == PRE)};
  assign bus.err_short_blank = err;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: directed and random lines compared with an
// offset-based reference model built from input history.
module tb_hdmi_period_sequencer;
  localparam int P   = 8;
  localparam int G   = 2;
  localparam int LAT = P + G + 1;
  localparam int NH  = 32768;

  logic pixclk = 1'b0;
  logic rst    = 1'b1;

  hdmi_period_sequencer_if bus();

  hdmi_period_sequencer #(.PREAMBLE_LEN(P), .GUARD_LEN(G)) dut (
    .pixclk (pixclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #20 pixclk = ~pixclk;

  int errors = 0;
  int checks = 0;

  bit          h_de  [NH];
  bit          h_hs  [NH];
  bit          h_vs  [NH];
  logic [23:0] h_rgb [NH];
  int          cyc  = 0;
  int          base = 0;
  bit          prev_de = 1'b1;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [1:0]  x_period = 2'b00;
  bit          x_err = 1'b0;
  bit          x_de, x_hs, x_vs;
  logic [23:0] x_rgb;

  // Reference: period derived from the offset since the accepted rise and the
  // de value that leaves the LAT-cycle history at this edge.
  always @(posedge pixclk) begin : model
    int e, o, off;
    bit rise;
    e = cyc;
    cyc++;
    if (rst) begin
      base     = cyc;
      prev_de  = 1'b1;
      m_active = 1'b0;
      x_period = 2'b00;
      x_err    = 1'b0;
    end else begin
      h_de[e]  = bus.de_in;
      h_hs[e]  = bus.hsync_in;
      h_vs[e]  = bus.vsync_in;
      h_rgb[e] = bus.rgb_in;
      rise     = bus.de_in && !prev_de;
      prev_de  = bus.de_in;
      if (rise && x_period != 2'b00) x_err = 1'b1;
      else if (bus.err_clr) x_err = 1'b0;
      if (rise && x_period == 2'b00) begin
        m_active = 1'b1;
        m_start  = e;
      end
    end
    o = e - LAT + 1;
    if (o >= base && o >= 0) begin
      x_de = h_de[o]; x_hs = h_hs[o]; x_vs = h_vs[o]; x_rgb = h_rgb[o];
    end else begin
      x_de = 1'b0; x_hs = 1'b0; x_vs = 1'b0; x_rgb = 24'd0;
    end
    if (!rst) begin
      off = e - m_start;
      if (!m_active) x_period = 2'b00;
      else if (off < P) x_period = 2'b01;
      else if (off < P + G) x_period = 2'b10;
      else if (x_de) x_period = 2'b11;
      else begin
        x_period = 2'b00;
        m_active = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("period", 32'(bus.period_out), 32'(x_period));
    chk("vde",    32'(bus.vde_out),    32'(x_period == 2'b11));
    chk("ctl",    32'(bus.ctl_out),    (x_period == 2'b01) ? 32'd1 : 32'd0);
    chk("guard",  32'(bus.guard_out),  32'(x_period == 2'b10));
    chk("rgb",    32'(bus.rgb_out),    32'(x_rgb));
    chk("hsync",  32'(bus.hsync_out),  32'(x_hs));
    chk("vsync",  32'(bus.vsync_out),  32'(x_vs));
    chk("err",    32'(bus.err_short_blank), 32'(x_err));
  endtask

  task automatic step(input bit de, input bit hs, input bit vs,
                      input logic [23:0] rgb, input bit clr);
    bus.de_in    = de;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.rgb_in   = rgb;
    bus.err_clr  = clr;
    @(posedge pixclk);
    @(negedge pixclk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_rgb"},    32'(bus.rgb_out),    32'd0);
    chk({tag, "_hsync"},  32'(bus.hsync_out),  32'd0);
    chk({tag, "_vsync"},  32'(bus.vsync_out),  32'd0);
    chk({tag, "_vde"},    32'(bus.vde_out),    32'd0);
    chk({tag, "_ctl"},    32'(bus.ctl_out),    32'd0);
    chk({tag, "_guard"},  32'(bus.guard_out),  32'd0);
    chk({tag, "_period"}, 32'(bus.period_out), 32'd0);
    chk({tag, "_err"},    32'(bus.err_short_blank), 32'd0);
  endtask

  initial begin
    bus.de_in = 1'b1; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.rgb_in = 24'd0; bus.err_clr = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge pixclk);
      @(negedge pixclk);
      check_all();
    end
    zero_outputs("reset");
    rst = 1'b0;

    // Line already active at release must never be sequenced
    run(640);
    chk("held_line_period", 32'(bus.period_out), 32'd0);
    blank(160);

    // Standard 800-cycle lines, 640 active
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 640; i++)
        step(1'b1, 1'b0, (l == 1), 24'($urandom), 1'b0);
      for (int i = 0; i < 160; i++)
        step(1'b0, (i >= 16 && i < 112), (l == 1), 24'($urandom), 1'b0);
    end

    // Single-cycle active pulse
    run(1);
    blank(20);
    chk("pulse_err", 32'(bus.err_short_blank), 32'd0);

    // Minimum accepted blanking, then one cycle short
    run(5); blank(11); run(5); blank(20);
    chk("blank11_err", 32'(bus.err_short_blank), 32'd0);
    run(5); blank(10); run(5); blank(20);
    chk("blank10_err", 32'(bus.err_short_blank), 32'd1);

    // Clear alone, then set and clear in the same cycle
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    chk("clr_alone", 32'(bus.err_short_blank), 32'd0);
    run(3); blank(2);
    step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b1);
    chk("set_wins", 32'(bus.err_short_blank), 32'd1);
    run(2); blank(20);
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    chk("clr_later", 32'(bus.err_short_blank), 32'd0);

    // Random runs and gaps with occasional clears
    for (int s = 0; s < 60; s++) begin
      run($urandom_range(1, 20));
      for (int i = 0, n = $urandom_range(1, 16); i < n; i++)
        step(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), ($urandom_range(0, 15) == 0));
    end
    blank(20);

    // Reset during VIDEO
    run(LAT + 9);
    chk("pre_reset_vde", 32'(bus.vde_out), 32'd1);
    @(posedge pixclk);
    #5 rst = 1'b1;
    #1 zero_outputs("async_rst");
    @(negedge pixclk);
    bus.de_in = 1'b0;
    repeat (2) begin
      @(posedge pixclk);
      @(negedge pixclk);
      check_all();
    end
    rst = 1'b0;
    blank(15);
    run(10);
    blank(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
